alu_result_fifo: RTL and testbench
==================================

Name: alu_result_fifo

Overview:
- Downstream stage of the signed ALU top. Consumes its four registered result buses and one-hot unit flags each clock and merges them into one tagged 32-bit word.
- Buffers words in a FIFO and presents them to a consumer over a valid/ready handshake.
- Flags overflow and illegal (non-one-hot) flag patterns with sticky status bits.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2
- ADDR_WIDTH, 3, log2(DEPTH)
- Arith_Out_WIDTH, 32, arithmetic bus width; also the output data width
- Logic_Out_WIDTH, 16, logic bus width
- CMP_Out_WIDTH, 2, compare bus width
- Shift_Out_WIDTH, 17, shift bus width

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous active-low reset
- Arith_OUT  in  32  signed arithmetic result
- Logic_OUT  in  16  logic result
- CMP_OUT  in  2  compare result
- SHIFT_OUT  in  17  shift result
- Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag  in  1 each  unit-valid flags
- CLR  in  1  synchronous clear of sticky status
- RES_DATA  out  32  head-entry result
- RES_TAG  out  2  head-entry source: 00 arith, 01 logic, 10 cmp, 11 shift
- RES_VALID  out  1  FIFO not empty
- RES_READY  in  1  consumer accepts head
- FIFO_COUNT  out  ADDR_WIDTH+1  occupancy
- FULL  out  1  occupancy equals DEPTH
- OVF  out  1  sticky: a result was dropped
- ILLEGAL  out  1  sticky: more than one flag high in one cycle

Behaviour:
- Reset (RST=0, asynchronous) clears the following: pointers, FIFO_COUNT=0, RES_VALID=0, FULL=0, OVF=0, ILLEGAL=0, RES_DATA=0, RES_TAG=0. FIFO storage contents are don't-care.
- Push request: exactly one flag high on a CLK edge.
- Data formatting on push:
  - arith: stored as is
  - logic: zero-extended
  - cmp: zero-extended
  - shift: zero-extended 17→32
- Zero flags high: no push, no status change.
- Two or more flags high: no push; ILLEGAL set on that edge.
- Pop: RES_VALID && RES_READY on a CLK edge. The read pointer advances and RES_DATA/RES_TAG update combinationally from storage at the new head.
- Pointers wrap modulo DEPTH. FIFO_COUNT updates as follows:
  - +1 on push only
  - −1 on pop only
  - unchanged on simultaneous push and pop
- Latency: a word pushed on edge N is visible on RES_DATA with RES_VALID=1 after edge N. There is no same-cycle bypass when empty.
- Full with push and no pop: word dropped, OVF set, storage and pointers unchanged.
- Full with push and pop on the same edge: both occur, count stays DEPTH, no OVF.
- Empty with RES_READY=1: no pop, pointers unchanged.
- CLR=1: OVF and ILLEGAL cleared on that edge; FIFO contents untouched. If CLR coincides with a new overflow or illegal event, the event wins and the bit stays 1.
- Reset asserted mid-operation: immediate flush to reset values regardless of CLK. Flags present on the first edge after RST deasserts are captured normally.
- RES_DATA/RES_TAG are don't-care while RES_VALID=0, but must not be X after reset.

Optional Feature:
- Macro: ALU_RESULT_FIFO_DROP_CNT_EN.
- When defined:
  - adds output DROP_CNT[7:0], reset 0, cleared by CLR
  - increments once per dropped word and saturates at 255
  - increments even when the CLR edge coincides with a drop, taking the value 1 on that edge
- When undefined: port and counter are absent; OVF behaviour is identical.

Test Plan:
- Single arith push: Arith_OUT=32'hFFFFFFE1, Arith_Flag=1 for one cycle, RES_READY=0 -> after that edge RES_VALID=1, RES_DATA=FFFFFFE1, RES_TAG=00, FIFO_COUNT=1.
- Zero-extension: SHIFT_OUT=17'h1FFFF, SHIFT_Flag=1 -> RES_DATA=0001FFFF, RES_TAG=11. CMP_OUT=2'b11, CMP_Flag=1 -> 00000003, tag 10.
- Fill and overflow: 9 logic pushes 0x0001..0x0009 with RES_READY=0 -> FULL=1, FIFO_COUNT=8, OVF=1, DROP_CNT=1 (feature on). Draining yields 1..8 in order; 9 is absent.
- Full with simultaneous push and pop: at count 8, push 0xAAAA with RES_READY=1 -> count stays 8, OVF unchanged, 0xAAAA emerges last.
- Illegal flags: Arith_Flag=Logic_Flag=1 -> count unchanged, ILLEGAL=1. CLR pulse -> ILLEGAL=0, OVF=0.
- Async reset mid-stream: with 5 entries queued, drive RST=0 between edges -> FIFO_COUNT=0, RES_VALID=0 immediately. After release, one push is seen correctly.

Source files
------------

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - tagged ALU result merge FIFO with sticky overflow/illegal status (optional drop counter: ALU_RESULT_FIFO_DROP_CNT_EN)
module alu_result_fifo #(
  parameter int DEPTH           = 8,
  parameter int ADDR_WIDTH      = 3,
  parameter int Arith_Out_WIDTH = 32,
  parameter int Logic_Out_WIDTH = 16,
  parameter int CMP_Out_WIDTH   = 2,
  parameter int Shift_Out_WIDTH = 17
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [Arith_Out_WIDTH-1:0] Arith_OUT,
  input  logic [Logic_Out_WIDTH-1:0] Logic_OUT,
  input  logic [CMP_Out_WIDTH-1:0]   CMP_OUT,
  input  logic [Shift_Out_WIDTH-1:0] SHIFT_OUT,
  input  logic                       Arith_Flag,
  input  logic                       Logic_Flag,
  input  logic                       CMP_Flag,
  input  logic                       SHIFT_Flag,
  input  logic                       CLR,
  output logic [Arith_Out_WIDTH-1:0] RES_DATA,
  output logic [1:0]                 RES_TAG,
  output logic                       RES_VALID,
  input  logic                       RES_READY,
  output logic [ADDR_WIDTH:0]        FIFO_COUNT,
  output logic                       FULL,
  output logic                       OVF,
  output logic                       ILLEGAL
`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]                 DROP_CNT
`endif
);

  // Each entry holds the tag in the top two bits above the formatted data.
  localparam int WORD_W = Arith_Out_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [WORD_W-1:0]     mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  illegal_q, illegal_d;

  logic [2:0]            flag_cnt;
  logic                  push_req;
  logic                  illegal_evt;
  logic                  full;
  logic                  pop;
  logic                  push_ok;
  logic                  drop_evt;
  logic [WORD_W-1:0]     in_word;
  logic [WORD_W-1:0]     head_word;

  // Classify the flag pattern and format the incoming result into a tagged word.
  always_comb begin
    flag_cnt    = 3'(Arith_Flag) + 3'(Logic_Flag) + 3'(CMP_Flag) + 3'(SHIFT_Flag);
    push_req    = (flag_cnt == 3'd1);
    illegal_evt = (flag_cnt >= 3'd2);
    in_word     = '0;
    if (Arith_Flag) begin
      in_word = {2'b00, Arith_OUT};
    end else if (Logic_Flag) begin
      in_word = {2'b01, {(Arith_Out_WIDTH-Logic_Out_WIDTH){1'b0}}, Logic_OUT};
    end else if (CMP_Flag) begin
      in_word = {2'b10, {(Arith_Out_WIDTH-CMP_Out_WIDTH){1'b0}}, CMP_OUT};
    end else if (SHIFT_Flag) begin
      in_word = {2'b11, {(Arith_Out_WIDTH-Shift_Out_WIDTH){1'b0}}, SHIFT_OUT};
    end
  end

  // Push/pop decisions; a full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    full     = (count_q == DEPTH_C);
    pop      = (count_q != '0) && RES_READY;
    push_ok  = push_req && (!full || pop);
    drop_evt = push_req && full && !pop;

    wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push_ok) begin
      count_d = count_q - CNT_ONE;
    end

    // A new event on the clear edge wins over the clear.
    ovf_d     = (CLR ? 1'b0 : ovf_q) | drop_evt;
    illegal_d = (CLR ? 1'b0 : illegal_q) | illegal_evt;
  end

  // Storage carries no reset; the output mux hides stale contents while empty.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= in_word;
    end
  end

  // Pointer, occupancy and sticky status registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
    end
  end

  // Head presentation; forced to zero while empty so reset never exposes X.
  always_comb begin
    head_word  = mem_q[rd_ptr_q];
    RES_VALID  = (count_q != '0);
    RES_DATA   = RES_VALID ? head_word[Arith_Out_WIDTH-1:0] : '0;
    RES_TAG    = RES_VALID ? head_word[WORD_W-1:Arith_Out_WIDTH] : 2'b00;
    FIFO_COUNT = count_q;
    FULL       = full;
    OVF        = ovf_q;
    ILLEGAL    = illegal_q;
  end

`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped words; a drop on the clear edge restarts it at one.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (CLR) begin
      drop_cnt_d = drop_evt ? 8'd1 : 8'd0;
    end else if (drop_evt && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign DROP_CNT = drop_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb/tb_alu_result_fifo.sv - randomized and directed bench for alu_result_fifo against a queue model
module tb_alu_result_fifo;
  localparam int DEPTH = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] Arith_OUT = '0;
  logic [15:0] Logic_OUT = '0;
  logic [1:0]  CMP_OUT = '0;
  logic [16:0] SHIFT_OUT = '0;
  logic        Arith_Flag = 1'b0, Logic_Flag = 1'b0, CMP_Flag = 1'b0, SHIFT_Flag = 1'b0;
  logic        CLR = 1'b0;
  logic [31:0] RES_DATA;
  logic [1:0]  RES_TAG;
  logic        RES_VALID;
  logic        RES_READY = 1'b0;
  logic [3:0]  FIFO_COUNT;
  logic        FULL, OVF, ILLEGAL;
`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
  logic [7:0]  DROP_CNT;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic [33:0] mq[$];
  bit          m_ovf = 1'b0, m_ill = 1'b0;
  int          m_drop = 0;

  alu_result_fifo dut (
    .CLK(CLK), .RST(RST),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .SHIFT_Flag(SHIFT_Flag),
    .CLR(CLR),
    .RES_DATA(RES_DATA), .RES_TAG(RES_TAG), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .FIFO_COUNT(FIFO_COUNT), .FULL(FULL), .OVF(OVF), .ILLEGAL(ILLEGAL)
`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
    , .DROP_CNT(DROP_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {tag,data} words updated from the edge's inputs.
  always @(posedge CLK or negedge RST) begin
    int n;
    bit pop, was_full, push, drop;
    logic [33:0] w;
    if (!RST) begin
      mq.delete();
      m_ovf = 1'b0;
      m_ill = 1'b0;
      m_drop = 0;
    end else begin
      n = int'(Arith_Flag) + int'(Logic_Flag) + int'(CMP_Flag) + int'(SHIFT_Flag);
      if (Arith_Flag)      w = {2'd0, Arith_OUT};
      else if (Logic_Flag) w = {2'd1, 16'd0, Logic_OUT};
      else if (CMP_Flag)   w = {2'd2, 30'd0, CMP_OUT};
      else                 w = {2'd3, 15'd0, SHIFT_OUT};
      was_full = (mq.size() == DEPTH);
      pop  = (mq.size() != 0) && RES_READY;
      push = (n == 1) && (!was_full || pop);
      drop = (n == 1) && was_full && !pop;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(w);
      m_ovf = (CLR ? 1'b0 : m_ovf) | drop;
      m_ill = (CLR ? 1'b0 : m_ill) | (n >= 2);
      if (CLR) m_drop = drop ? 1 : 0;
      else if (drop && m_drop < 255) m_drop++;
    end
  end

  // Single compare process: every falling edge, DUT outputs versus the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("cmp_valid", 64'(RES_VALID), 64'(mq.size() != 0));
      check("cmp_count", 64'(FIFO_COUNT), 64'(mq.size()));
      check("cmp_full", 64'(FULL), 64'(mq.size() == DEPTH));
      check("cmp_ovf", 64'(OVF), 64'(m_ovf));
      check("cmp_illegal", 64'(ILLEGAL), 64'(m_ill));
`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
      check("cmp_drop_cnt", 64'(DROP_CNT), 64'(m_drop));
`endif
      if (mq.size() != 0) begin
        check("cmp_data", 64'(RES_DATA), 64'(mq[0][31:0]));
        check("cmp_tag", 64'(RES_TAG), 64'(mq[0][33:32]));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic clear_flags();
    Arith_Flag = 1'b0; Logic_Flag = 1'b0; CMP_Flag = 1'b0; SHIFT_Flag = 1'b0;
  endtask

  task automatic push(input int unit, input logic [31:0] val);
    clear_flags();
    case (unit)
      0: begin Arith_OUT = val; Arith_Flag = 1'b1; end
      1: begin Logic_OUT = val[15:0]; Logic_Flag = 1'b1; end
      2: begin CMP_OUT = val[1:0]; CMP_Flag = 1'b1; end
      default: begin SHIFT_OUT = val[16:0]; SHIFT_Flag = 1'b1; end
    endcase
    tick();
    clear_flags();
  endtask

  task automatic pop_one();
    RES_READY = 1'b1;
    tick();
    RES_READY = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_count", 64'(FIFO_COUNT), 64'd0);
    check("rst_valid", 64'(RES_VALID), 64'd0);
    check("rst_full", 64'(FULL), 64'd0);
    check("rst_ovf", 64'(OVF), 64'd0);
    check("rst_illegal", 64'(ILLEGAL), 64'd0);
    check("rst_data", 64'(RES_DATA), 64'd0);
    check("rst_tag", 64'(RES_TAG), 64'd0);
    #6 RST = 1'b1;
    chk_en = 1'b1;
    #1;

    // Single arithmetic push.
    push(0, 32'hFFFF_FFE1);
    check("arith_valid", 64'(RES_VALID), 64'd1);
    check("arith_data", 64'(RES_DATA), 64'hFFFF_FFE1);
    check("arith_tag", 64'(RES_TAG), 64'd0);
    check("arith_count", 64'(FIFO_COUNT), 64'd1);
    pop_one();
    check("arith_drained", 64'(RES_VALID), 64'd0);

    // Zero extension of shift and compare results.
    push(3, 32'h0001_FFFF);
    check("shift_data", 64'(RES_DATA), 64'h0001_FFFF);
    check("shift_tag", 64'(RES_TAG), 64'd3);
    push(2, 32'h3);
    pop_one();
    check("cmp_data_lit", 64'(RES_DATA), 64'h3);
    check("cmp_tag_lit", 64'(RES_TAG), 64'd2);
    pop_one();

    // Fill and overflow.
    for (int i = 1; i <= 9; i++) push(1, 32'(i));
    check("fill_full", 64'(FULL), 64'd1);
    check("fill_count", 64'(FIFO_COUNT), 64'd8);
    check("fill_ovf", 64'(OVF), 64'd1);
`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
    check("fill_drop_cnt", 64'(DROP_CNT), 64'd1);
`endif
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", 64'(RES_DATA), 64'(i));
      pop_one();
    end
    check("drain_empty", 64'(RES_VALID), 64'd0);
    CLR = 1'b1; tick(); CLR = 1'b0;
    check("clr_ovf", 64'(OVF), 64'd0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 8; i++) push(1, 32'h10 + 32'(i));
    Logic_OUT = 16'hAAAA; Logic_Flag = 1'b1; RES_READY = 1'b1;
    tick();
    clear_flags(); RES_READY = 1'b0;
    check("fullpp_count", 64'(FIFO_COUNT), 64'd8);
    check("fullpp_ovf", 64'(OVF), 64'd0);
    for (int i = 1; i < 8; i++) begin
      check("fullpp_order", 64'(RES_DATA), 64'h10 + 64'(i));
      pop_one();
    end
    check("fullpp_last", 64'(RES_DATA), 64'hAAAA);
    check("fullpp_last_count", 64'(FIFO_COUNT), 64'd1);

    // Illegal flag pattern, then clear.
    Arith_Flag = 1'b1; Logic_Flag = 1'b1;
    tick();
    clear_flags();
    check("ill_count", 64'(FIFO_COUNT), 64'd1);
    check("ill_set", 64'(ILLEGAL), 64'd1);
    CLR = 1'b1; tick(); CLR = 1'b0;
    check("ill_clr", 64'(ILLEGAL), 64'd0);
    check("ill_clr_ovf", 64'(OVF), 64'd0);
    pop_one();

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) push(0, 32'h100 + 32'(i));
    check("pre_rst_count", 64'(FIFO_COUNT), 64'd5);
    RST = 1'b0;
    #1;
    check("async_count", 64'(FIFO_COUNT), 64'd0);
    check("async_valid", 64'(RES_VALID), 64'd0);
    #1 RST = 1'b1;
    push(0, 32'h1234_5678);
    check("post_rst_data", 64'(RES_DATA), 64'h1234_5678);
    check("post_rst_count", 64'(FIFO_COUNT), 64'd1);

    // Randomized traffic; readiness bias alternates to exercise full and empty regions.
    for (int c = 0; c < 3000; c++) begin
      int r, u, u2, rdy_pct;
      clear_flags();
      Arith_OUT = $urandom();
      Logic_OUT = 16'($urandom());
      CMP_OUT   = 2'($urandom());
      SHIFT_OUT = 17'($urandom());
      r = $urandom_range(0, 9);
      u = $urandom_range(0, 3);
      if (r >= 2) begin
        case (u)
          0: Arith_Flag = 1'b1;
          1: Logic_Flag = 1'b1;
          2: CMP_Flag = 1'b1;
          default: SHIFT_Flag = 1'b1;
        endcase
      end
      if (r == 9) begin
        u2 = (u + $urandom_range(1, 3)) % 4;
        case (u2)
          0: Arith_Flag = 1'b1;
          1: Logic_Flag = 1'b1;
          2: CMP_Flag = 1'b1;
          default: SHIFT_Flag = 1'b1;
        endcase
      end
      rdy_pct = ((c / 300) % 2 == 0) ? 20 : 80;
      RES_READY = ($urandom_range(0, 99) < rdy_pct);
      CLR = ($urandom_range(0, 39) == 0);
      tick();
    end
    clear_flags();
    RES_READY = 1'b0;
    CLR = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
